// File: rtl/proc_mem_responder.sv
// proc_mem_responder: word memory answering requests in order after a fixed latency.
// Define PROC_MEM_RESPONDER_SUBWORD_EN to enable byte/halfword/3-byte access via len.

package proc_mem_pkg;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   localparam logic [2:0] MEM_READ  = 3'd0;
   localparam logic [2:0] MEM_WRITE = 3'd1;
   localparam logic [2:0] MEM_INIT  = 3'd2;

endpackage

module proc_mem_responder
   import proc_mem_pkg::*;
#(
   parameter int NUM_WORDS = 256,
   parameter int LATENCY   = 2,
   parameter int DEPTH     = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  mem_req_4B_t  memreq_msg,
   input  logic         memreq_val,
   output logic         memreq_rdy,
   output mem_resp_4B_t memresp_msg,
   output logic         memresp_val,
   input  logic         memresp_rdy
);

   localparam int IW = $clog2(NUM_WORDS);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int NS = 2 ** PW;

   localparam logic [3:0]    LAT_SAT = 4'(LATENCY);
   localparam logic [3:0]    LAT_VIS = 4'(LATENCY - 1);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   logic [31:0]   mem_q [NUM_WORDS];
   logic [IW-1:0] idx;
   logic [31:0]   word;
   logic [31:0]   wmask;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          is_wr;
   logic          push;
   logic          pop;
   mem_resp_4B_t  resp;

   mem_resp_4B_t  buf_q [NS];
   logic [3:0]    age_q [NS];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full;
   logic          empty;

   logic          unused_ok;

   assign idx   = memreq_msg.addr[IW+1:2];
   assign word  = mem_q[idx];
   assign is_wr = (memreq_msg.type_ == MEM_WRITE) ||
                  (memreq_msg.type_ == MEM_INIT);

   assign unused_ok = ^{memreq_msg.addr[31:IW+2],
                        memreq_msg.addr[1:0]};

`ifdef PROC_MEM_RESPONDER_SUBWORD_EN
   logic [4:0]  shamt;
   logic [31:0] lmask;

   // len selects the lane width; shamt moves the lane to/from bit 0
   always_comb begin
      shamt = 5'd0;
      lmask = 32'hffff_ffff;
      unique case (memreq_msg.len)
         2'd1: begin
            shamt = {memreq_msg.addr[1:0], 3'b000};
            lmask = 32'h0000_00ff;
         end
         2'd2: begin
            shamt = {memreq_msg.addr[1], 4'b0000};
            lmask = 32'h0000_ffff;
         end
         2'd3: lmask = 32'h00ff_ffff;
         default: ;
      endcase
   end

   assign wmask = lmask << shamt;
   assign wdata = (memreq_msg.data & lmask) << shamt;
   assign rdata = (word >> shamt) & lmask;
`else
   assign wmask = 32'hffff_ffff;
   assign wdata = memreq_msg.data;
   assign rdata = word;
`endif

   always_ff @(posedge clk) begin
      if (push && is_wr) begin
         mem_q[idx] <= (word & ~wmask) | (wdata & wmask);
      end
   end

   always_comb begin
      resp        = '0;
      resp.type_  = memreq_msg.type_;
      resp.opaque = memreq_msg.opaque;
      resp.len    = memreq_msg.len;
      resp.data   = is_wr ? 32'd0 : rdata;
   end

   assign full  = (cnt_q == FULL);
   assign empty = (cnt_q == '0);

   assign memreq_rdy  = !reset && !full;
   assign memresp_val = !reset && !empty &&
                        (age_q[head_q] >= LAT_VIS);
   assign memresp_msg = reset ? '0 : buf_q[head_q];

   assign push = memreq_val && memreq_rdy;
   assign pop  = memresp_val && memresp_rdy;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (pop) begin
         head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      if (push) begin
         tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // ages run freely and saturate; a push restarts its slot at 0
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < NS; i++) begin
            age_q[i] <= '0;
            buf_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         for (int i = 0; i < NS; i++) begin
            if (age_q[i] != LAT_SAT) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end
         if (push) begin
            buf_q[tail_q] <= resp;
            age_q[tail_q] <= '0;
         end
      end
   end

endmodule

// File: doc/proc_mem_responder.md
PROC_MEM_RESPONDER -- requirements
Module: proc_mem_responder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256: number of 32-bit words stored; power of two.
REQ-002 SHALL have parameter LATENCY, default 2: minimum cycles from request accept edge to response valid; legal range 1..15.
REQ-003 SHALL have parameter DEPTH, default 2: number of outstanding responses buffered; power of two, at least 1.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port memreq_msg, input, mem_req_4B_t: request with fields type_, opaque, addr, len, data.
REQ-007 SHALL have port memreq_val, input, 1: request valid.
REQ-008 SHALL have port memreq_rdy, output, 1: request accepted when val and rdy are both high at posedge.
REQ-009 SHALL have port memresp_msg, output, mem_resp_4B_t: response with fields type_, opaque, test, len, data.
REQ-010 SHALL have port memresp_val, output, 1: response valid.
REQ-011 SHALL have port memresp_rdy, input, 1: response consumed when val and rdy are both high at posedge.

Function
REQ-012 SHALL compute word index as addr[2+log2(NUM_WORDS)-1:2]; higher address bits are ignored, so addresses wrap modulo NUM_WORDS*4.
REQ-013 SHALL perform the array access at the accept edge, in accept order, so a read accepted after a write to the same address returns the written data.
REQ-014 SHALL treat type_ READ (0) as a read, and WRITE (1) or INIT (2) as a write; other type_ values SHALL be treated as reads.
REQ-015 SHALL return read data in the response data field; write/INIT responses SHALL carry data=0.
REQ-016 SHALL echo type_, opaque, and len from the request into the response, and SHALL drive test=0.
REQ-017 SHALL enqueue each accepted response into a DEPTH-entry FIFO with a per-entry age counter that starts at 0 and saturates at LATENCY.
REQ-018 SHALL assert memresp_val only when the FIFO is non-empty and the head entry's age counter has reached LATENCY-1 or greater; a request accepted at edge t is therefore visible no earlier than the cycle after edge t+LATENCY-1.
REQ-019 SHALL drive memresp_msg from the head entry and hold it stable while memresp_val=1 and memresp_rdy=0.
REQ-020 SHALL drive memreq_rdy = !full, with no same-cycle pop-to-push bypass; when full, a pop in the same cycle SHALL NOT raise rdy in that cycle.
REQ-021 SHALL, on simultaneous push and pop, update the count unchanged and advance both pointers; pointers SHALL wrap modulo DEPTH.
REQ-022 SHALL return responses strictly in request order.

Reset
REQ-023 SHALL, while reset=1, drive memreq_rdy=0 and memresp_val=0, and clear the pointers, count, and age counters; memresp_msg SHALL be 0.
REQ-024 SHALL drop all in-flight responses when reset is asserted mid-operation; memory array contents SHALL NOT be reset.
REQ-025 SHALL drive memreq_rdy=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, when macro PROC_MEM_RESPONDER_SUBWORD_EN is defined, decode len as 0=4 bytes, 1=byte at lane addr[1:0], 2=halfword at lane addr[1], 3=3 bytes at lane 0.
REQ-027 SHALL, with the macro defined, zero-extend subword read data into the low bits of the response data, and make subword writes modify only the addressed bytes.
REQ-028 SHALL, without the macro, treat every access as a full word, ignoring len for the access (len is still echoed) and ignoring addr[1:0].

Verification
REQ-029 SHALL verify: write addr 0x10 data 0xDEADBEEF, then read 0x10 with LATENCY=2 -> read response data 0xDEADBEEF, opaque echoed, val asserted exactly 2 cycles after the accept edge.
REQ-030 SHALL verify: hold memresp_rdy=0 and issue 3 reads with DEPTH=2 -> rdy drops after the 2nd accept; releasing rdy returns 2 responses in order, then the 3rd request is accepted.
REQ-031 SHALL verify: write addr 0x400 with NUM_WORDS=256, then read 0x0 -> data equals the written value (address wrap).
REQ-032 SHALL verify, with SUBWORD_EN: write word 0x11223344 at 0x20, then byte write 0xAA at 0x21, then read word -> 0x1122AA44; a byte read of 0x23 -> 0x00000011.
REQ-033 SHALL verify: assert reset with 2 responses pending -> val=0 during reset; after reset no stale responses appear and rdy=1 in the first cycle.
REQ-034 SHALL verify: back-to-back push and pop every cycle with LATENCY=1 and DEPTH=1 -> rdy=0 while full, throughput 1 response per 2 cycles, no loss or duplication.
